// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the vector-RAM port arbiter.
// Optional statistics counters are built under VRAM_ARB_STATS_EN.
package vram_arb_pkg;

    localparam int VRAM_ADDR_W = 13;

    localparam logic [15:0] VRAM_BASE_DEF = 16'h2000;
    localparam logic [15:0] VRAM_SIZE_DEF = 16'h2000;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        RUN
    } arb_state_t;

endpackage

// File: rtl/vram_port_arbiter_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
// Used by the arbiter statistics (VRAM_ARB_STATS_EN).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the vector-RAM BRAM port between queued CPU stores and VG reads.
// Statistics counters are built only when VRAM_ARB_STATS_EN is defined.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter logic [15:0] VRAM_BASE  = VRAM_BASE_DEF,
    parameter logic [15:0] VRAM_SIZE  = VRAM_SIZE_DEF,
    parameter int          STREAK_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             q_data,
    input  logic [15:0]            q_addr,
    input  logic                   q_empty,
    output logic                   can_write,
    input  logic                   vg_go,
    input  logic                   vg_rst,
    input  logic                   vg_done,
    output logic                   vg_start,
    input  logic                   vg_req,
    input  logic [VRAM_ADDR_W-1:0] vg_addr,
    output logic                   vg_gnt,
    output logic [7:0]             vg_rdata,
    output logic                   vg_rvalid,
    output logic [VRAM_ADDR_W-1:0] bram_addr,
    output logic [7:0]             bram_wdata,
    output logic                   bram_we,
    input  logic [7:0]             bram_rdata,
    output logic                   drop_err,
    output logic [15:0]            wr_count,
    output logic [15:0]            rd_count,
    output logic [15:0]            stall_count
);

    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [SW-1:0] streak;
    logic          rd_pend;
    logic [15:0]   offset;
    logic          in_win;
    logic          starve;

    assign offset = q_addr - VRAM_BASE;
    assign in_win = (q_addr >= VRAM_BASE) && (offset < VRAM_SIZE);
    assign starve = (streak == STREAK_LIM) && !q_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (vg_go) state_nxt = FLUSH;
            FLUSH:   if (q_empty) state_nxt = RUN;
            RUN:     if (vg_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (vg_rst) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        can_write = 1'b0;
        vg_gnt    = 1'b0;
        vg_start  = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    can_write = !q_empty;
                end
                FLUSH: begin
                    can_write = !q_empty;
                    vg_start  = q_empty && !vg_rst;
                end
                RUN: begin
                    vg_gnt    = vg_req && !starve;
                    can_write = !q_empty && !(vg_req && !starve);
                end
                default: begin
                    can_write = 1'b0;
                end
            endcase
        end
    end

    // Streak only tracks back-to-back VG grants while the VG is running
    always_ff @(posedge clk) begin
        if (rst || vg_rst || (state != RUN)) begin
            streak <= '0;
        end else if (vg_gnt) begin
            if (streak != STREAK_LIM) begin
                streak <= streak + 1'b1;
            end
        end else if (can_write || !vg_req) begin
            streak <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            drop_err   <= 1'b0;
        end else begin
            bram_we <= 1'b0;
            if (can_write) begin
                if (in_win) begin
                    bram_we    <= 1'b1;
                    bram_addr  <= offset[VRAM_ADDR_W-1:0];
                    bram_wdata <= q_data;
                end else begin
                    drop_err <= 1'b1;
                end
            end else if (vg_gnt) begin
                bram_addr <= vg_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || vg_rst) begin
            rd_pend   <= 1'b0;
            vg_rvalid <= 1'b0;
        end else begin
            rd_pend   <= vg_gnt;
            vg_rvalid <= rd_pend;
        end
    end

    assign vg_rdata = bram_rdata;

`ifdef VRAM_ARB_STATS_EN
    logic stall;

    assign stall = (state == RUN) && vg_req && !vg_gnt;

    sat_counter #(.W(16)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (bram_we),
        .count (wr_count)
    );

    sat_counter #(.W(16)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (vg_gnt),
        .count (rd_count)
    );

    sat_counter #(.W(16)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall),
        .count (stall_count)
    );
`else
    assign wr_count    = '0;
    assign rd_count    = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: store-queue and BRAM models, a per-cycle
// reference model, and directed scenarios with literal expectations.
module tb_vram_port_arbiter;

    localparam int BASE = 'h2000;
    localparam int SIZE = 'h2000;
    localparam int SMAX = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  q_data;
    logic [15:0] q_addr;
    logic        q_empty;
    logic        can_write;
    logic        vg_go;
    logic        vg_rst;
    logic        vg_done;
    logic        vg_start;
    logic        vg_req;
    logic [12:0] vg_addr;
    logic        vg_gnt;
    logic [7:0]  vg_rdata;
    logic        vg_rvalid;
    logic [12:0] bram_addr;
    logic [7:0]  bram_wdata;
    logic        bram_we;
    logic [7:0]  bram_rdata;
    logic        drop_err;
    logic [15:0] wr_count;
    logic [15:0] rd_count;
    logic [15:0] stall_count;

    vram_port_arbiter #(
        .VRAM_BASE  (16'h2000),
        .VRAM_SIZE  (16'h2000),
        .STREAK_MAX (SMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .q_data      (q_data),
        .q_addr      (q_addr),
        .q_empty     (q_empty),
        .can_write   (can_write),
        .vg_go       (vg_go),
        .vg_rst      (vg_rst),
        .vg_done     (vg_done),
        .vg_start    (vg_start),
        .vg_req      (vg_req),
        .vg_addr     (vg_addr),
        .vg_gnt      (vg_gnt),
        .vg_rdata    (vg_rdata),
        .vg_rvalid   (vg_rvalid),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .bram_we     (bram_we),
        .bram_rdata  (bram_rdata),
        .drop_err    (drop_err),
        .wr_count    (wr_count),
        .rd_count    (rd_count),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:8191];

    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_wdata;
        bram_rdata <= mem[bram_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: mode 0 idle, 1 flush, 2 run
    int       mcyc   = 0;
    int       mode   = 0;
    int       streak = 0;
    bit       e_we   = 0;
    int       e_addr = 0;
    int       e_wd   = 0;
    bit       e_drop = 0;
    int       c_wr   = 0;
    int       c_rd   = 0;
    int       c_st   = 0;
    int       rd_due[$];
    bit       x_cw;
    bit       x_gnt;
    bit       x_st;
    bit       x_rv;
    bit       inwin;
    int       off;
    logic [31:0] off_v;

    always @(negedge clk) begin
        x_cw  = 0;
        x_gnt = 0;
        x_st  = 0;
        if (!rst) begin
            if (mode == 2) begin
                x_gnt = vg_req && !(streak == SMAX && !q_empty);
                x_cw  = !q_empty && !x_gnt;
            end else begin
                x_cw = !q_empty;
                x_st = (mode == 1) && q_empty && !vg_rst;
            end
        end
        x_rv = 0;
        foreach (rd_due[i]) if (rd_due[i] == mcyc) x_rv = 1;

        chk("can_write", 32'(can_write), 32'(x_cw));
        chk("vg_gnt", 32'(vg_gnt), 32'(x_gnt));
        chk("vg_start", 32'(vg_start), 32'(x_st));
        chk("vg_rvalid", 32'(vg_rvalid), 32'(x_rv));
        chk("bram_we", 32'(bram_we), 32'(e_we));
        chk("bram_addr", 32'(bram_addr), e_addr);
        chk("bram_wdata", 32'(bram_wdata), e_wd);
        chk("drop_err", 32'(drop_err), 32'(e_drop));
`ifdef VRAM_ARB_STATS_EN
        chk("wr_count", 32'(wr_count), c_wr);
        chk("rd_count", 32'(rd_count), c_rd);
        chk("stall_count", 32'(stall_count), c_st);
`else
        chk("wr_count", 32'(wr_count), 0);
        chk("rd_count", 32'(rd_count), 0);
        chk("stall_count", 32'(stall_count), 0);
`endif

        if (rst) begin
            mode   = 0;
            streak = 0;
            e_we   = 0;
            e_addr = 0;
            e_wd   = 0;
            e_drop = 0;
            c_wr   = 0;
            c_rd   = 0;
            c_st   = 0;
            rd_due.delete();
        end else begin
            if (e_we && c_wr < 65535) c_wr++;
            if (x_gnt && c_rd < 65535) c_rd++;
            if (mode == 2 && vg_req && !x_gnt && c_st < 65535) c_st++;
            e_we = 0;
            off = int'(q_addr) - BASE;
            inwin = (int'(q_addr) >= BASE) && (int'(q_addr) < BASE + SIZE);
            if (x_cw) begin
                if (inwin) begin
                    off_v  = off;
                    e_we   = 1;
                    e_addr = int'(off_v[12:0]);
                    e_wd   = int'(q_data);
                end else begin
                    e_drop = 1;
                end
            end else if (x_gnt) begin
                e_addr = int'(vg_addr);
            end
            rd_due = rd_due.find(d) with (d > mcyc);
            if (vg_rst) rd_due.delete();
            else if (x_gnt) rd_due.push_back(mcyc + 2);
            if (vg_rst || mode != 2) streak = 0;
            else if (x_gnt) streak = (streak < SMAX) ? streak + 1 : SMAX;
            else if (x_cw || !vg_req) streak = 0;
            if (vg_rst) mode = 0;
            else if (mode == 0 && vg_go) mode = 1;
            else if (mode == 1 && q_empty) mode = 2;
            else if (mode == 2 && vg_done) mode = 0;
        end
        mcyc++;
    end

    // Store queue model and per-cycle observation log
    logic [23:0] sq[$];
    logic [23:0] wlog[$];
    int          tcyc = 0;
    int          cw_cnt;
    int          start_cnt;
    int          start_cyc;
    int          last_pop;
    int          gnt_cnt;
    int          first_gnt;
    int          rv_cnt;
    int          rv_cyc;
    logic [7:0]  rv_data;
    logic [6:0]  gseq;
    logic [6:0]  cseq;

    task automatic refresh();
        q_empty = (sq.size() == 0);
        if (sq.size() != 0) begin
            q_addr = sq[0][23:8];
            q_data = sq[0][7:0];
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        sq.push_back({a, d});
        refresh();
    endtask

    task automatic clear_log();
        wlog.delete();
        cw_cnt    = 0;
        start_cnt = 0;
        start_cyc = -1;
        last_pop  = -1;
        gnt_cnt   = 0;
        first_gnt = -1;
        rv_cnt    = 0;
        rv_cyc    = -1;
        rv_data   = 8'h00;
        gseq      = '0;
        cseq      = '0;
    endtask

    task automatic tick();
        bit pop;
        @(negedge clk);
        pop = can_write && !q_empty;
        if (can_write) cw_cnt++;
        if (pop) last_pop = tcyc;
        if (bram_we) wlog.push_back({3'b000, bram_addr, bram_wdata});
        if (vg_start) begin
            start_cnt++;
            start_cyc = tcyc;
        end
        if (vg_gnt) begin
            gnt_cnt++;
            if (first_gnt < 0) first_gnt = tcyc;
        end
        if (vg_rvalid) begin
            rv_cnt++;
            if (rv_cyc < 0) begin
                rv_cyc  = tcyc;
                rv_data = vg_rdata;
            end
        end
        gseq = {gseq[5:0], vg_gnt};
        cseq = {cseq[5:0], can_write};
        @(posedge clk);
        #1;
        if (pop) void'(sq.pop_front());
        refresh();
        tcyc++;
    endtask

    function automatic logic [23:0] wl(input int i);
        if (i < wlog.size()) return wlog[i];
        return 24'hFFFFFF;
    endfunction

    initial begin
        rst     = 1'b1;
        q_data  = 8'h00;
        q_addr  = 16'h0000;
        q_empty = 1'b1;
        vg_go   = 1'b0;
        vg_rst  = 1'b0;
        vg_done = 1'b0;
        vg_req  = 1'b0;
        vg_addr = 13'h0000;
        clear_log();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_bram_we", 32'(bram_we), 0);
        chk("rst_bram_addr", 32'(bram_addr), 0);
        chk("rst_drop_err", 32'(drop_err), 0);
        chk("rst_vg_rvalid", 32'(vg_rvalid), 0);

        // Drain in IDLE
        clear_log();
        push(16'h2000, 8'hA1);
        push(16'h2001, 8'hB2);
        push(16'h3FFF, 8'hC3);
        repeat (6) tick();
        chk("drain_writes", wlog.size(), 3);
        chk("drain_w0", 32'(wl(0)), 32'h0000A1);
        chk("drain_w1", 32'(wl(1)), 32'h0001B2);
        chk("drain_w2", 32'(wl(2)), 32'h1FFFC3);
        chk("drain_cw_cycles", cw_cnt, 3);

        push(16'h2123, 8'h5A);
        repeat (3) tick();

        // Flush before start, then first read latency
        clear_log();
        for (int i = 0; i < 5; i++) begin
            push(16'h2010 + 16'(i), 8'h10 + 8'(i));
        end
        vg_go   = 1'b1;
        vg_req  = 1'b1;
        vg_addr = 13'h0123;
        tick();
        vg_go = 1'b0;
        for (int i = 0; i < 20 && start_cnt == 0; i++) tick();
        repeat (4) tick();
        chk("flush_writes", wlog.size(), 5);
        chk("flush_last_w", 32'(wl(4)), 32'h001414);
        chk("flush_start_cnt", start_cnt, 1);
        chk("flush_start_cyc", start_cyc, last_pop + 1);
        chk("flush_first_gnt", first_gnt, start_cyc + 1);
        chk("read_rv_cyc", rv_cyc, first_gnt + 2);
        chk("read_rdata", 32'(rv_data), 32'h5A);

        // Starvation guard
        vg_req = 1'b0;
        tick();
        clear_log();
        push(16'h2050, 8'h77);
        vg_req = 1'b1;
        repeat (7) tick();
        chk("starve_gnt_seq", 32'(gseq), 32'b1111011);
        chk("starve_cw_seq", 32'(cseq), 32'b0000100);
`ifdef VRAM_ARB_STATS_EN
        chk("starve_stall_cnt", 32'(stall_count), 1);
`else
        chk("starve_stall_cnt", 32'(stall_count), 0);
`endif

        // Out-of-window stores below and at the top edge
        vg_req = 1'b0;
        repeat (3) tick();
        clear_log();
        push(16'h1800, 8'h99);
        push(16'h4000, 8'h98);
        repeat (4) tick();
        chk("oow_writes", wlog.size(), 0);
        chk("oow_pops", cw_cnt, 2);
        chk("oow_q_empty", 32'(q_empty), 1);
        chk("oow_drop_err", 32'(drop_err), 1);
        vg_done = 1'b1;
        tick();
        vg_done = 1'b0;
        repeat (3) tick();
        chk("oow_drop_sticky", 32'(drop_err), 1);

        // VG reset right after a grant, with a colliding go
        clear_log();
        vg_go = 1'b1;
        tick();
        vg_go   = 1'b0;
        vg_req  = 1'b1;
        vg_addr = 13'h0123;
        for (int i = 0; i < 10 && gnt_cnt == 0; i++) tick();
        chk("vrst_got_gnt", gnt_cnt, 1);
        vg_rst = 1'b1;
        vg_go  = 1'b1;
        vg_req = 1'b0;
        tick();
        vg_rst = 1'b0;
        vg_go  = 1'b0;
        vg_req = 1'b1;
        clear_log();
        repeat (4) tick();
        chk("vrst_no_rvalid", rv_cnt, 0);
        chk("vrst_no_start", start_cnt, 0);
        chk("vrst_idle_no_gnt", gnt_cnt, 0);
        vg_req = 1'b0;

        // Reset clears the sticky flag and blocks pops
        clear_log();
        push(16'h2100, 8'h42);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst2_no_pop", cw_cnt, 0);
        chk("rst2_drop_clr", 32'(drop_err), 0);
        repeat (3) tick();
        chk("rst2_writes", wlog.size(), 1);
        chk("rst2_w0", 32'(wl(0)), 32'h010042);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Owns the single vector-RAM BRAM port and shares it between two clients: CPU stores drained from the memory store queue, and vector-generator (VG) display-list reads. Sits directly downstream of the store queue; it drives the queue's `canWrite` and consumes its head entry. On a VG go it drains every queued store before starting the VG, so the VG never reads stale display lists. While the VG runs, it arbitrates with a starvation guard.

## Interface

Parameters:
- `VRAM_BASE`, default `16'h2000`: CPU address of vector RAM word 0.
- `VRAM_SIZE`, default `16'h2000`: window size in bytes.
- `STREAK_MAX`, default `4`: maximum consecutive VG grants while stores are pending.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk` in, 1: system clock.
- `rst` in, 1: synchronous active-high reset.
- `q_data` in, 8: store queue head data.
- `q_addr` in, 16: store queue head CPU address.
- `q_empty` in, 1: store queue empty.
- `can_write` out, 1: pop strobe to the queue; the queue pops on the edge where this is high and the queue is not empty.
- `vg_go` in, 1: single-cycle go pulse from the address decoder.
- `vg_rst` in, 1: VG reset pulse.
- `vg_done` in, 1: VG halted pulse.
- `vg_start` out, 1: single-cycle start pulse to the VG.
- `vg_req` in, 1: VG read request.
- `vg_addr` in, 13: VG word address.
- `vg_gnt` out, 1: VG read accepted this cycle.
- `vg_rdata` out, 8: read data (passthrough of `bram_rdata`).
- `vg_rvalid` out, 1: `vg_rdata` is valid.
- `bram_addr` out, 13: registered BRAM address.
- `bram_wdata` out, 8: registered BRAM write data.
- `bram_we` out, 1: registered BRAM write enable.
- `bram_rdata` in, 8: BRAM read data, 1-cycle latency.
- `drop_err` out, 1: sticky flag; a store outside the window was popped.
- `wr_count`, `rd_count`, `stall_count` out, 16 each: statistics counters (see Configuration).

## Operation

- FSM states are IDLE, FLUSH and RUN. Reset state is IDLE.
- **IDLE**
  - `can_write = !q_empty`, `vg_gnt = 0`.
  - `vg_go` moves the FSM to FLUSH.
- **FLUSH**
  - Same drain behaviour as IDLE.
  - In the first cycle with `q_empty` high, assert `vg_start` for 1 cycle and go to RUN.
  - If `vg_go` arrives while the queue is already empty, FLUSH lasts exactly 1 cycle.
- **RUN**
  - `vg_gnt = vg_req && !(streak == STREAK_MAX && !q_empty)`.
  - `can_write = !q_empty && !vg_gnt`.
  - `streak` increments on each VG grant and clears on a CPU grant or when `vg_req` is low. It never exceeds `STREAK_MAX`.
  - `vg_done` moves the FSM to IDLE.
- **`vg_rst`**
  - In any state: go to IDLE, clear `streak`, and squash `vg_rvalid` for any read in flight.
  - `vg_rst` has priority over a simultaneous `vg_go` or `vg_done`.
- `vg_go` in FLUSH or RUN is ignored.
- **CPU grant** (cycle where `can_write` is high)
  - If `VRAM_BASE <= q_addr < VRAM_BASE+VRAM_SIZE`: next cycle `bram_we=1`, `bram_addr=q_addr-VRAM_BASE` (truncated to 13 bits), `bram_wdata=q_data`.
  - Otherwise the entry is popped and discarded, and `drop_err` is set. `drop_err` is cleared only by `rst`.
- **VG grant**: next cycle `bram_we=0`, `bram_addr=vg_addr`.
- **No grant**: `bram_we=0`; `bram_addr` and `bram_wdata` hold their values.

## Timing

- Grants are combinational from the registered state plus current inputs. The BRAM command is registered.
- Write: grant at cycle N, BRAM write at edge N+1.
- Read: grant at cycle N, `bram_addr` valid in N+1, `vg_rvalid=1` with data in N+2. The VG may be granted back-to-back, giving one datum per cycle.
- Drain rate is 1 store per cycle.
- Worst-case store latency in RUN with the queue non-empty: `STREAK_MAX+1` cycles.
- Reset values are all 0: `bram_we`, `bram_addr`, `bram_wdata`, `vg_rvalid`, `vg_start`, `drop_err`, `streak` and the counters.
- `can_write` and `vg_gnt` are forced to 0 during `rst`.
- Reset mid-read: the pending `vg_rvalid` is dropped.

## Configuration

- Macro: `VRAM_ARB_STATS_EN`.
- Defined:
  - `wr_count` counts issued BRAM writes.
  - `rd_count` counts VG grants.
  - `stall_count` counts cycles with `vg_req=1 && vg_gnt=0` in RUN.
  - Each counter is 16-bit and saturates at `16'hFFFF`.
- Undefined: the three outputs are tied to 0 and no counter logic is built.

## Structure

- Package `vram_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, FLUSH, RUN);
  - `VRAM_ADDR_W = 13`;
  - the default `VRAM_BASE` and `VRAM_SIZE` constants.
- Sub-module `sat_counter #(W)` has inputs `en` and `rst` and output `count`. It is instantiated 3 times, only under `VRAM_ARB_STATS_EN`.

## Test plan

- **Drain in IDLE:** queue holds 3 stores to 0x2000/0x2001/0x3FFF with data A1/B2/C3 → `bram_we` pulses on 3 consecutive cycles at 0x0000/0x0001/0x1FFF with A1/B2/C3; `can_write` high for exactly 3 cycles.
- **Flush before start:** queue has 5 entries, `vg_go` pulse → exactly 5 writes, then `vg_start` 1 cycle after the last pop; no `vg_gnt` before `vg_start`.
- **Starvation guard:** RUN, `vg_req` held high, 1 store queued, `STREAK_MAX=4` → 4 VG grants, 1 CPU grant, then VG grants resume; `stall_count=1` with `VRAM_ARB_STATS_EN`.
- **Read latency:** `vg_addr=0x0123` granted at cycle N, BRAM preloaded with 0x5A → `vg_rvalid=1` and `vg_rdata=0x5A` at N+2.
- **Out-of-window store:** store to 0x1800 → popped, `bram_we` stays 0, `drop_err=1` and stays set until `rst`.
- **VG reset:** `vg_rst` asserted the cycle after a VG grant, with `vg_go` in the same cycle → state IDLE, no `vg_rvalid`, no `vg_start`.
